// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants used by the receiver, transmitter and rx controller.
//   UART_DATA_W : default byte width
//   UART_DEPTH  : default rx FIFO depth (power of two, >= 2)
//   PTR_W       : FIFO pointer width convention, $clog2(depth)
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int UART_DEPTH  = 4;
    localparam int PTR_W       = $clog2(UART_DEPTH);
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: valid/ready byte stream from the rx controller to its consumer.
//   valid : head byte present (master -> slave)
//   data  : head byte (master -> slave)
//   ready : consumer accepts the head byte (slave -> master)
interface uart_rx_ctrl_if #(
    parameter int DATA_W = uart_pkg::UART_DATA_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word fall-through synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write request; accepted when not full, or when full and a pop happens too
//   i_data     : write data
//   i_pop      : read request; ignored when empty
//   o_data     : head entry (0 while empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_count    : entries held, 0..DEPTH
module uart_sync_fifo import uart_pkg::*; #(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = r_count == CNT_W'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    // Storage is not reset; gating on empty keeps the head at 0 after reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    // A simultaneous pop frees the slot the push needs.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: captures each completed receiver frame into a FIFO and streams it out.
//   clk, rst_n  : clock (shared with receiver), asynchronous active-low reset
//   enable      : 1 = capture completed frames
//   rx_rdy      : receiver ready level, rises at frame completion
//   rx_data     : receiver byte, stable while rx_rdy is high
//   out_if      : valid/ready byte stream to the consumer (master side)
//   count       : bytes held, 0..DEPTH
//   overrun     : sticky, a frame was dropped while full
//   overrun_clr : pulse clearing overrun (a same-cycle drop wins)
module uart_rx_ctrl import uart_pkg::*; #(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   rx_rdy,
    input  logic [DATA_W-1:0]      rx_data,
    uart_rx_ctrl_if.master         out_if,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    input  logic                   overrun_clr
);
    logic              r_rdy_q;
    logic              r_overrun;
    logic              w_frame;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_data;

    // r_rdy_q resets high so a byte already held at reset release is not captured.
    assign w_frame      = rx_rdy & ~r_rdy_q & enable;
    // Full implies valid, so only a missing ready turns a frame into a drop.
    assign w_drop       = w_frame & w_full & ~out_if.ready;
    assign out_if.valid = ~w_empty;
    assign out_if.data  = w_data;
    assign overrun      = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_q   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_rdy_q   <= rx_rdy;
            r_overrun <= w_drop | (r_overrun & ~overrun_clr);
        end
    end

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_frame),
        .i_data  (rx_data),
        .i_pop   (out_if.ready),
        .o_data  (w_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b1;
    logic       rx_rdy = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic [2:0] count;
    logic       overrun;
    logic       overrun_clr = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    uart_rx_ctrl_if #(.DATA_W(8)) out_if ();

    uart_rx_ctrl #(.DATA_W(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .out_if      (out_if),
        .count       (count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Low rdy for one cycle, then rising edge with byte d; optional same-cycle pop / clear.
    task automatic frame(input logic [7:0] d, input logic pop = 1'b0, input logic clr = 1'b0);
        rx_rdy = 1'b0;
        @(negedge clk);
        rx_rdy      = 1'b1;
        rx_data     = d;
        out_if.ready = pop;
        overrun_clr = clr;
        @(negedge clk);
        out_if.ready = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check({tag, "_valid"}, 32'(out_if.valid), 32'd1);
        check({tag, "_data"}, 32'(out_if.data), 32'(d));
        out_if.ready = 1'b1;
        @(negedge clk);
        out_if.ready = 1'b0;
    endtask

    initial begin
        out_if.ready = 1'b0;
        rx_data = 8'hA5;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_if.valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(out_if.data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t1_valid", 32'(out_if.valid), 32'd0);
            check("t1_count", 32'(count), 32'd0);
        end

        frame(8'hE0);
        check("t2_valid", 32'(out_if.valid), 32'd1);
        check("t2_data", 32'(out_if.data), 32'hE0);
        check("t2_count", 32'(count), 32'd1);
        repeat (10) @(negedge clk);
        check("t2_hold_count", 32'(count), 32'd1);
        check("t2_hold_data", 32'(out_if.data), 32'hE0);
        pop_expect("t2_pop", 8'hE0);
        check("t2_empty", 32'(count), 32'd0);

        for (int i = 1; i <= 4; i++) frame(8'(i));
        check("t3_full_count", 32'(count), 32'd4);
        check("t3_no_ovr", 32'(overrun), 32'd0);
        frame(8'h05);
        check("t3_drop_count", 32'(count), 32'd4);
        check("t3_ovr", 32'(overrun), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect("t3_pop", 8'(i));
        check("t3_drained", 32'(count), 32'd0);
        check("t3_drained_valid", 32'(out_if.valid), 32'd0);
        out_if.ready = 1'b1;
        @(negedge clk);
        out_if.ready = 1'b0;
        check("t3_empty_ready", 32'(count), 32'd0);
        frame(8'h77, 1'b1);
        check("t3_empty_pushpop", 32'(count), 32'd1);
        check("t3_empty_pushpop_data", 32'(out_if.data), 32'h77);
        pop_expect("t3_pop77", 8'h77);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t3_ovr_clr", 32'(overrun), 32'd0);

        for (int i = 1; i <= 4; i++) frame(8'(i));
        frame(8'h10, 1'b1);
        check("t4_count", 32'(count), 32'd4);
        check("t4_ovr", 32'(overrun), 32'd0);
        pop_expect("t4_pop", 8'h02);
        pop_expect("t4_pop", 8'h03);
        pop_expect("t4_pop", 8'h04);
        pop_expect("t4_pop", 8'h10);
        check("t4_drained", 32'(count), 32'd0);

        frame(8'h11);
        frame(8'h22);
        frame(8'h33);
        frame(8'h44);
        frame(8'h55);
        check("t5_ovr_set", 32'(overrun), 32'd1);
        frame(8'h66, 1'b0, 1'b1);
        check("t5_set_wins", 32'(overrun), 32'd1);
        check("t5_count", 32'(count), 32'd4);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t5_clr", 32'(overrun), 32'd0);
        pop_expect("t5_pop", 8'h11);
        pop_expect("t5_pop", 8'h22);
        pop_expect("t5_pop", 8'h33);
        pop_expect("t5_pop", 8'h44);
        check("t5_drained", 32'(count), 32'd0);

        frame(8'hA1);
        frame(8'hA2);
        check("t6_count2", 32'(count), 32'd2);
        enable = 1'b0;
        frame(8'h3C);
        check("t6_disabled", 32'(count), 32'd2);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_late_enable", 32'(count), 32'd2);
        check("t6_head", 32'(out_if.data), 32'hA1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_if.valid), 32'd0);
        check("t6_async_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_post_rst_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
